// File: rtl/accel_pkg.sv
// Shared types and constants for the accelerometer BCD conversion path.
// Holds the converter FSM encoding, the default digit count and the BCD nibble width.
package accel_pkg;

  localparam int DIGITS_DEF = 5;
  localparam int NIB_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ABS   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/bcd_nibble_adj.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
module bcd_nibble_adj
  import accel_pkg::*;
(
  input  logic [NIB_W-1:0] nib_in,
  output logic [NIB_W-1:0] nib_out
);

  assign nib_out = (nib_in >= 4'd5) ? (nib_in + 4'd3) : nib_in;

endmodule

// File: rtl/accel_bcd_convert.sv
// Signed axis sample to sign + packed BCD, using a bit-serial double-dabble engine.
// A one-deep pending slot absorbs strobes that arrive while a conversion is running.
module accel_bcd_convert
  import accel_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_valid,
  input  logic [DATA_W-1:0]     sample_in,
  output logic                  sign,
  output logic [NIB_W*DIGITS-1:0] bcd,
  output logic                  bcd_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam int ACC_W = NIB_W * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic [DATA_W-1:0] pend_q, pend_d;
  logic              pend_full_q, pend_full_d;
  logic              overrun_q, overrun_d;
  logic              sign_lat_q, sign_lat_d;
  logic [DATA_W-1:0] mag_q, mag_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sign_q, sign_d;
  logic [ACC_W-1:0]  bcd_q, bcd_d;
  logic              bcd_valid_q, bcd_valid_d;
  logic [ACC_W-1:0]  acc_adj;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_nibble_adj u_adj (
        .nib_in  (acc_q[gi*NIB_W +: NIB_W]),
        .nib_out (acc_adj[gi*NIB_W +: NIB_W])
      );
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    sample_d    = sample_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    overrun_d   = overrun_q;
    sign_lat_d  = sign_lat_q;
    mag_d       = mag_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sign_d      = sign_q;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      // Pending sample goes first; a simultaneous new strobe refills the slot.
      if (pend_full_q) begin
        sample_d    = pend_q;
        pend_full_d = 1'b0;
        state_d     = ST_ABS;
        if (sample_valid) begin
          pend_d      = sample_in;
          pend_full_d = 1'b1;
        end
      end else if (sample_valid) begin
        sample_d = sample_in;
        state_d  = ST_ABS;
      end
    end else if (sample_valid) begin
      pend_d      = sample_in;
      pend_full_d = 1'b1;
      if (pend_full_q) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      ST_ABS: begin
        sign_lat_d = sample_q[DATA_W-1];
        // Unsigned result, so the most negative input maps to 2^(DATA_W-1) cleanly.
        mag_d      = sample_q[DATA_W-1] ? (~sample_q + DATA_W'(1)) : sample_q;
        acc_d      = '0;
        cnt_d      = '0;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        {acc_d, mag_d} = {acc_adj, mag_q} << 1;
        cnt_d          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        bcd_d       = acc_q;
        sign_d      = sign_lat_q;
        bcd_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sample_q    <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      sign_lat_q  <= 1'b0;
      mag_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sign_q      <= 1'b0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sample_q    <= sample_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      overrun_q   <= overrun_d;
      sign_lat_q  <= sign_lat_d;
      mag_q       <= mag_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sign_q      <= sign_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign sign      = sign_q;
  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign busy      = (state_q != ST_IDLE) || pend_full_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_accel_bcd_convert.sv
// Directed-vector and scenario bench for accel_bcd_convert (default 16-bit, 5 digits).
module tb_accel_bcd_convert;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sign;
  logic [19:0] bcd;
  logic        bcd_valid;
  logic        busy;
  logic        overrun;

  int n_vec = 0;
  int n_bad = 0;

  accel_bcd_convert #(.DATA_W(16), .DIGITS(5)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .sign         (sign),
    .bcd          (bcd),
    .bcd_valid    (bcd_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic        es;
    logic [19:0] eb;
  } vec_t;

  vec_t vt[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Decimal reference: sign in bit 20, five BCD digits below.
  function automatic logic [20:0] ref_bcd(input logic [15:0] s);
    int m;
    logic [19:0] r;
    m = (s[15]) ? (65536 - int'(s)) : int'(s);
    r = '0;
    for (int i = 0; i < 5; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return {s[15], r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 100; k++) begin
      if (!busy) break;
      tick();
    end
    if (k == 100) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_idle: busy stuck got 1 expected 0");
    end
  endtask

  task automatic run_vec(input logic [15:0] d, input logic es, input logic [19:0] eb,
                         input string tag);
    int lat;
    wait_idle();
    sample_in    = d;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bcd_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'd18);
    chk({tag, "_sign"}, 32'(sign), 32'(es));
    chk({tag, "_bcd"}, 32'(bcd), 32'(eb));
    tick();
    chk({tag, "_pulse_len"}, 32'(bcd_valid), 32'd0);
    chk({tag, "_hold"}, 32'(bcd), 32'(eb));
  endtask

  initial begin
    int pulses;
    logic [19:0] got[4];
    logic [20:0] r;
    logic [15:0] d;
    int last_pulse;

    vt[0] = '{16'h0000, 1'b0, 20'h00000};
    vt[1] = '{16'hFF9C, 1'b1, 20'h00100};
    vt[2] = '{16'h00FF, 1'b0, 20'h00255};
    vt[3] = '{16'h7FFF, 1'b0, 20'h32767};
    vt[4] = '{16'h8000, 1'b1, 20'h32768};
    vt[5] = '{16'h0001, 1'b0, 20'h00001};
    vt[6] = '{16'hFFFF, 1'b1, 20'h00001};
    vt[7] = '{16'h2710, 1'b0, 20'h10000};
    vt[8] = '{16'h0D05, 1'b0, 20'h03333};

    // Reset state
    repeat (3) tick();
    chk("rst_sign", 32'(sign), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_valid", 32'(bcd_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_vec(vt[i].din, vt[i].es, vt[i].eb, $sformatf("vec%0d", i));
      $display("vector %0d: in=%04h sign=%0d bcd=%05h", i, vt[i].din, sign, bcd);
    end
    chk("no_overrun_serial", 32'(overrun), 32'd0);

    // Reset in the middle of a conversion of 999
    wait_idle();
    sample_in = 16'd999;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    repeat (10) tick();
    chk("mid_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_sign", 32'(sign), 32'd0);
    chk("mid_rst_bcd", 32'(bcd), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(bcd_valid), 32'd0);
    pulses = 0;
    repeat (3) begin
      tick();
      if (bcd_valid) pulses++;
    end
    reset_n = 1'b1;
    repeat (25) begin
      tick();
      if (bcd_valid) pulses++;
    end
    chk("mid_rst_no_pulse", 32'(pulses), 32'd0);
    chk("mid_rst_idle", 32'(busy), 32'd0);
    run_vec(16'd5, 1'b0, 20'h00005, "after_rst");
    $display("reset mid-conversion: pulses=%0d then bcd=%05h", pulses, bcd);

    // Back-to-back strobes: 1234, then 42 and 7 while busy (7 must win)
    wait_idle();
    sample_in = 16'd1234; sample_valid = 1'b1; tick();
    sample_valid = 1'b0; tick();
    tick();
    sample_in = 16'd42; sample_valid = 1'b1; tick();
    sample_valid = 1'b0; tick();
    sample_in = 16'd7; sample_valid = 1'b1; tick();
    sample_valid = 1'b0;
    pulses = 0;
    for (int k = 0; k < 60; k++) begin
      if (bcd_valid) begin
        if (pulses < 4) got[pulses] = bcd;
        pulses++;
      end
      tick();
    end
    chk("b2b_pulses", 32'(pulses), 32'd2);
    chk("b2b_first", 32'(got[0]), 32'h01234);
    chk("b2b_second", 32'(got[1]), 32'h00007);
    chk("b2b_overrun", 32'(overrun), 32'd1);
    $display("back-to-back: pulses=%0d first=%05h second=%05h overrun=%0d",
             pulses, got[0], got[1], overrun);

    reset_n = 1'b0;
    tick();
    chk("overrun_cleared", 32'(overrun), 32'd0);
    reset_n = 1'b1;
    tick();

    // Random samples against the decimal reference
    for (int i = 0; i < 1000; i++) begin
      d = 16'($urandom);
      r = ref_bcd(d);
      run_vec(d, r[20], r[19:0], $sformatf("rnd%0d_%04h", i, d));
      if (i % 100 == 0) $display("random %0d: in=%04h sign=%0d bcd=%05h", i, d, sign, bcd);
    end

    // Continuous strobes: check result spacing
    wait_idle();
    sample_valid = 1'b1;
    pulses = 0;
    last_pulse = -1;
    for (int k = 0; k < 120; k++) begin
      sample_in = 16'($urandom);
      tick();
      if (bcd_valid) begin
        if (last_pulse >= 0) begin
          chk($sformatf("spacing_ok_%0d", pulses), 32'(k - last_pulse >= 19), 32'd1);
          $display("continuous: pulse %0d spacing %0d", pulses, k - last_pulse);
        end
        last_pulse = k;
        pulses++;
      end
    end
    sample_valid = 1'b0;
    chk("continuous_pulses_min", 32'(pulses >= 5), 32'd1);
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/accel_bcd_convert.md
Name: accel_bcd_convert

Overview:
Downstream consumer of the accelerometer SPI controller's sample outputs (data_x or data_y plus the data_update strobe).
Converts one signed two's-complement axis sample into a sign flag and packed decimal BCD digits, ready for the seg7 display decoders.
Uses a sequential shift-add-3 (double-dabble) engine, one bit per clock, so the logic stays small.
Sits between spi_control and the HEX digit decoders in the top-level accelerometer design.

Parameters:
DATA_W, 16, width of signed input sample (two's complement)
DIGITS, 5, number of BCD output digits; must satisfy 10^DIGITS > 2^(DATA_W-1)

Ports:
clk  input  1  system clock (25 MHz PLL c0 domain)
reset_n  input  1  asynchronous active-low reset
sample_valid  input  1  one-cycle strobe, sample present on sample_in (from data_update)
sample_in  input  DATA_W  signed axis sample
sign  output  1  1 = converted value was negative
bcd  output  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]
bcd_valid  output  1  one-cycle pulse: sign/bcd updated this cycle
busy  output  1  conversion in progress
overrun  output  1  sticky: a strobe arrived while pending slot already full; cleared only by reset

Behaviour:
- Reset (async assert, sync-safe deassert handled upstream):
  - sign=0, bcd=0, bcd_valid=0, busy=0, overrun=0.
  - State IDLE; pending slot empty.
- States:
  - IDLE: on sample_valid (or pending slot full), capture sample -> ABS. busy=0 only in IDLE with pending empty.
  - ABS: 1 cycle. Latch sign = sample MSB. Magnitude = sample negated if negative, held as unsigned DATA_W bits, so -2^(DATA_W-1) gives 2^(DATA_W-1) with no overflow. Clear BCD accumulator and bit counter -> SHIFT.
  - SHIFT: DATA_W cycles.
    - Each cycle, every accumulator nibble >= 5 gets +3, then {accumulator, magnitude} shifts left by 1.
    - Counter runs 0..DATA_W-1; at DATA_W-1 -> DONE.
  - DONE: 1 cycle. Register accumulator to bcd and latched sign to sign; bcd_valid=1. -> IDLE.
- Latency: strobe sampled at edge N; bcd_valid high in cycle N+DATA_W+2 (18 for default). Throughput is one sample per DATA_W+3 cycles.
- Outputs sign/bcd hold their last value between conversions; they only change on the bcd_valid cycle.
- Strobe while busy: stored in a one-deep pending slot, latest wins. If the slot is already full, overwrite it and set overrun. Pending is consumed on the IDLE cycle after DONE, so there is no gap beyond the mandatory IDLE cycle.
- Strobe in the DONE cycle: treated as busy (goes to pending).
- Zero input: sign=0, all digits 0. Negative zero is impossible in two's complement.
- Reset mid-conversion: abort immediately, outputs return to reset values, pending slot cleared, no bcd_valid pulse.
- sample_valid held high for multiple cycles: each high cycle counts as a new strobe.

Decomposition:
- Shared package accel_pkg:
  - state encoding constants (IDLE, ABS, SHIFT, DONE);
  - DIGITS default;
  - BCD nibble width constant 4.
- One sub-module is natural: bcd_nibble_adj, a combinational 4-bit "if >=5 add 3" cell, instantiated DIGITS times via generate.
- Counter width = clog2(DATA_W) computed locally.

Test Plan:
- Reset, then sample_in=16'h0000 strobe -> after 18 cycles bcd_valid=1, sign=0, bcd=20'h00000.
- sample_in=16'hFF9C (-100) -> sign=1, bcd=20'h00100. Then 16'h00FF -> sign=0, bcd=20'h00255.
- Extremes: 16'h7FFF -> sign=0, bcd=20'h32767. 16'h8000 -> sign=1, bcd=20'h32768.
- Back-to-back: strobes 16'd1234 at t, 16'd42 at t+3, 16'd7 at t+5 -> first result 01234; second result 00007 (latest wins); exactly 2 bcd_valid pulses; overrun=1.
- Reset asserted at cycle 10 of a conversion of 16'd999 -> outputs immediately 0, busy=0, no bcd_valid. After release, strobe 16'd5 -> bcd=20'h00005.
- Random signed samples (1000) checked against a reference model decimal conversion; check bcd_valid spacing >= 19 cycles under continuous strobes.
